// File: rtl/relu_maxpool2x2_if.sv
// Stream bundle between a conv filter stage and the ReLU/pool stage.
// Upstream drives the master side; the pool stage is the slave.
interface relu_maxpool2x2_if #(
   parameter int DATA_WIDTH = 32
);
   logic [DATA_WIDTH-1:0] data_in;
   logic                  valid_in;
   logic [DATA_WIDTH-1:0] data_out;
   logic                  valid_out;
   logic                  frame_done;

   modport master (
      output data_in,
      output valid_in,
      input  data_out,
      input  valid_out,
      input  frame_done
   );

   modport slave (
      input  data_in,
      input  valid_in,
      output data_out,
      output valid_out,
      output frame_done
   );
endinterface

// File: rtl/relu_maxpool2x2.sv
// Streaming ReLU followed by 2x2 stride-2 max pooling on a raster
// float32 feature map; no backpressure, one word per valid_in.
module relu_maxpool2x2 #(
   parameter int DATA_WIDTH = 32,
   parameter int WIDTH      = 32,
   parameter int HEIGHT     = 32
) (
   input logic              clk,
   input logic              rst,
   relu_maxpool2x2_if.slave bus
);
   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam int RW = (HEIGHT > 2) ? $clog2(HEIGHT) : 1;
   localparam int HW = WIDTH / 2;
   localparam int LW = (HW > 1) ? $clog2(HW) : 1;

   typedef logic [DATA_WIDTH-1:0] word_t;

   logic [CW-1:0] col;
   logic [RW-1:0] row;
   logic [LW-1:0] idx;
   logic          col_last;
   logic          row_last;

   word_t pair;
   word_t r;
   word_t p;
   word_t lb;
   word_t result;
   word_t line_buf [HW];

   // Post-ReLU words are non-negative, so an unsigned compare is the float max
   assign r        = bus.data_in[DATA_WIDTH-1] ? '0 : bus.data_in;
   assign p        = (pair > r) ? pair : r;
   assign idx      = LW'(col >> 1);
   assign lb       = line_buf[idx];
   assign result   = (p > lb) ? p : lb;
   assign col_last = (col == CW'(WIDTH - 1));
   assign row_last = (row == RW'(HEIGHT - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         bus.data_out   <= '0;
         bus.valid_out  <= 1'b0;
         bus.frame_done <= 1'b0;
         col            <= '0;
         row            <= '0;
         pair           <= '0;
      end else begin
         bus.valid_out  <= 1'b0;
         bus.frame_done <= 1'b0;
         if (bus.valid_in) begin
            if (!col[0]) begin
               pair <= r;
            end else if (row[0]) begin
               bus.data_out   <= result;
               bus.valid_out  <= 1'b1;
               bus.frame_done <= row_last && col_last;
            end
            if (col_last) begin
               col <= '0;
               row <= row_last ? '0 : row + RW'(1);
            end else begin
               col <= col + CW'(1);
            end
         end
      end
   end

   // Contents are don't-care after reset, so no reset branch here
   always_ff @(posedge clk) begin
      if (!rst && bus.valid_in && col[0] && !row[0]) begin
         line_buf[idx] <= p;
      end
   end
endmodule

// File: doc/relu_maxpool2x2.md
Name: relu_maxpool2x2

Overview:
- Streaming ReLU plus 2x2/stride-2 max-pooling stage for one layer-1 feature-map channel.
- Sits directly downstream of a featuremap_conv2d_0_filterN block and consumes its data_out/valid_out stream: IEEE-754 single-precision values, raster order, HEIGHT x WIDTH.
- Emits the pooled (HEIGHT/2) x (WIDTH/2) map in raster order for the next layer's input FIFO.
- No backpressure. The upstream stage cannot stall, so this block must accept one word on every cycle that valid_in is high.

Parameters:
- DATA_WIDTH, 32, word width; IEEE-754 single precision.
- WIDTH, 32, input feature-map columns; must be even and >= 2.
- HEIGHT, 32, input feature-map rows; must be even and >= 2.

Ports:
- clk  input  1  clock; all logic is on the rising edge.
- rst  input  1  synchronous reset, active-high.
- data_in  input  DATA_WIDTH  conv+bias result, float32.
- valid_in  input  1  data_in is valid this cycle.
- data_out  output  DATA_WIDTH  pooled value, float32, always >= +0.0.
- valid_out  output  1  data_out is valid; single-cycle pulse per pooled word.
- frame_done  output  1  one-cycle pulse together with the last pooled word of a frame.

Behaviour:
- Reset (rst=1 at a clock edge):
  - data_out=0, valid_out=0, frame_done=0.
  - col and row counters=0; pair register=0.
  - Line-buffer contents are don't-care.
  - Reset mid-frame discards the partial frame. The next valid_in word is treated as pixel (0,0).
- ReLU (combinational on data_in):
  - r = data_in[31] ? 0 : data_in. This maps -0.0 and all negatives to 0x00000000.
  - All post-ReLU values are non-negative, so the float max equals an unsigned integer compare of the 32-bit patterns. No FP comparator is required.
  - A positive NaN/Inf propagates as the largest value. A negative NaN becomes 0.
- Counters advance only on valid_in=1. Idle cycles hold all state.
  - col: 0..WIDTH-1. When it wraps, row increments.
  - row: 0..HEIGHT-1. When it wraps to 0, a new frame starts.
- Even col: pair register <= r.
- Odd col: p = max(pair, r).
  - Even row: line_buf[col>>1] <= p. No output.
  - Odd row: result = max(p, line_buf[col>>1]). Next cycle: data_out=result, valid_out=1.
- Latency: 1 clock from the valid_in edge of pixel (odd row, odd col) to valid_out.
  - data_out holds its last value while valid_out=0.
  - Back-to-back outputs are never closer than 2 cycles.
- frame_done=1 in the same cycle as the valid_out produced by input pixel (HEIGHT-1, WIDTH-1).
  - If valid_in is high on the following cycle, that word is pixel (0,0) of the next frame, with no dead cycle.
- Line buffer:
  - WIDTH/2 x DATA_WIDTH.
  - Written only in even rows; read only in odd rows at the same index.
  - A register array or 1R1W RAM is acceptable. With a synchronous-read RAM, the read must be issued on the even-col cycle so that latency stays at 1.
- Output count per frame: (HEIGHT/2)*(WIDTH/2), i.e. 256 at the defaults.
- Equal operands: either may be selected; the bit patterns are identical.

Test Plan:
- Reset: hold rst for 3 cycles with valid_in=1 → data_out=0, valid_out=0, frame_done=0 throughout, and no output afterwards until a 2x2 window completes.
- Single window, WIDTH=HEIGHT=2:
  - Stimulus: 0x3F800000 (1.0), 0x40000000 (2.0), 0xC0400000 (-3.0), 0x3F000000 (0.5), consecutive cycles.
  - Required response: exactly one cycle after the 4th word, data_out=0x40000000, valid_out=1, frame_done=1.
- All-negative window:
  - Stimulus: 0xBF800000, 0x80000000, 0xC1200000, 0xBDCCCCCD.
  - Required response: data_out=0x00000000 with valid_out=1.
- Full default frame, 32x32 with pixel value = row*32+col as float:
  - Required response: 256 outputs. Output k equals the float of (2*(k/16)+1)*32 + 2*(k%16)+1.
  - frame_done high only on output 255.
- Gapped input: the same 32x32 frame with valid_in randomly low ~50% of cycles → an identical output sequence. valid_out never asserts during a run of idle cycles except the one cycle after an odd/odd pixel.
- Mid-frame reset then restart: 40 pixels, rst for 1 cycle, then a full frame → exactly 256 outputs, all matching a clean-frame reference model.
